// File: rtl/vdu_writer.sv
// VDU-80 host-side VRAM writer: character writes, clear, scroll and scroll-offset publish.
// Optional sticky error flag o_err is compiled in when VDU_WRITER_ERR_EN is defined.
module vdu_writer #(
   parameter int          COLS       = 80,
   parameter int          ROWS       = 24,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [1:0]  i_cmd,
   input  logic [4:0]  i_row,
   input  logic [6:0]  i_col,
   input  logic [7:0]  i_char,
   input  logic [7:0]  i_attr,
   output logic [10:0] o_vram_addr,
   output logic [7:0]  o_char_data,
   output logic [7:0]  o_attr_data,
   output logic        o_vram_we,
   output logic [4:0]  o_counter,
   output logic        o_counter_valid
`ifdef VDU_WRITER_ERR_EN
   ,
   output logic        o_err
`endif
);

   localparam logic [4:0]  L_ROWS     = 5'(ROWS);
   localparam logic [5:0]  L_ROWS6    = 6'(ROWS);
   localparam logic [6:0]  L_COLS     = 7'(COLS);
   localparam logic [10:0] L_COLS11   = 11'(COLS);
   localparam logic [10:0] L_CELLS_M1 = 11'(COLS * ROWS - 1);
   localparam logic [10:0] L_COLS_M1  = 11'(COLS - 1);

   localparam logic [1:0] CMD_WRITE  = 2'b00;
   localparam logic [1:0] CMD_CLEAR  = 2'b01;
   localparam logic [1:0] CMD_SCROLL = 2'b10;
   localparam logic [1:0] CMD_SET    = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_PUBLISH} state_t;

   state_t      r_state;
   logic        r_ready;
   logic [4:0]  r_scroll;
   logic        r_counter_valid;
   logic [10:0] r_addr;
   logic [7:0]  r_char;
   logic [7:0]  r_attr;
   logic        r_we;
   logic [10:0] r_remain;
`ifdef VDU_WRITER_ERR_EN
   logic        r_err;
`endif

   logic        w_accept;
   logic [5:0]  w_sum;
   logic [4:0]  w_prow;
   logic        w_row_ok;
   logic        w_in_range;
   logic [10:0] w_wr_addr;
   logic [4:0]  w_scroll_inc;
   logic [10:0] w_old_base;

   assign w_accept     = i_valid && r_ready;
   // Row wrap without a divider: both operands are below ROWS, so one subtract suffices.
   assign w_sum        = {1'b0, i_row} + {1'b0, r_scroll};
   assign w_prow       = (w_sum >= L_ROWS6) ? 5'(w_sum - L_ROWS6) : w_sum[4:0];
   assign w_row_ok     = (i_row < L_ROWS);
   assign w_in_range   = w_row_ok && (i_col < L_COLS);
   assign w_wr_addr    = 11'(w_prow) * L_COLS11 + 11'(i_col);
   assign w_scroll_inc = (r_scroll == L_ROWS - 5'd1) ? 5'd0 : r_scroll + 5'd1;
   assign w_old_base   = 11'(r_scroll) * L_COLS11;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= S_IDLE;
         r_ready         <= 1'b1;
         r_scroll        <= 5'd0;
         r_counter_valid <= 1'b0;
         r_addr          <= 11'd0;
         r_char          <= 8'd0;
         r_attr          <= 8'd0;
         r_we            <= 1'b0;
         r_remain        <= 11'd0;
`ifdef VDU_WRITER_ERR_EN
         r_err           <= 1'b0;
`endif
      end else begin
         r_counter_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  case (i_cmd)
                     CMD_WRITE: begin
                        r_state <= S_WRITE;
                        r_we    <= w_in_range;
                        r_addr  <= w_wr_addr;
                        r_char  <= i_char;
                        r_attr  <= i_attr;
`ifdef VDU_WRITER_ERR_EN
                        if (!w_in_range) r_err <= 1'b1;
`endif
                     end
                     CMD_CLEAR: begin
                        r_state         <= S_FILL;
                        r_scroll        <= 5'd0;
                        r_counter_valid <= 1'b1;
                        r_we            <= 1'b1;
                        r_addr          <= 11'd0;
                        r_char          <= BLANK_CHAR;
                        r_attr          <= 8'h00;
                        r_remain        <= L_CELLS_M1;
`ifdef VDU_WRITER_ERR_EN
                        r_err           <= 1'b0;
`endif
                     end
                     CMD_SCROLL: begin
                        // The old top line becomes the new bottom line, so blank it.
                        r_state         <= S_FILL;
                        r_scroll        <= w_scroll_inc;
                        r_counter_valid <= 1'b1;
                        r_we            <= 1'b1;
                        r_addr          <= w_old_base;
                        r_char          <= BLANK_CHAR;
                        r_attr          <= 8'h00;
                        r_remain        <= L_COLS_M1;
                     end
                     default: begin
                        r_state <= S_PUBLISH;
                        if (w_row_ok) begin
                           r_scroll        <= i_row;
                           r_counter_valid <= 1'b1;
                        end
`ifdef VDU_WRITER_ERR_EN
                        else begin
                           r_err <= 1'b1;
                        end
`endif
                     end
                  endcase
               end
            end
            S_FILL: begin
               if (r_remain == 11'd0) begin
                  r_we    <= 1'b0;
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_addr   <= r_addr + 11'd1;
                  r_remain <= r_remain - 11'd1;
               end
            end
            default: begin
               r_we    <= 1'b0;
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready         = r_ready;
   assign o_vram_addr     = r_addr;
   assign o_char_data     = r_char;
   assign o_attr_data     = r_attr;
   assign o_vram_we       = r_we;
   assign o_counter       = r_scroll;
   assign o_counter_valid = r_counter_valid;
`ifdef VDU_WRITER_ERR_EN
   assign o_err           = r_err;
`endif

endmodule

// File: tb/tb_vdu_writer.sv
// Bench for vdu_writer: directed vector table, scroll sweep, mid-clear reset and
// random commands checked against a cell-level reference model.
module tb_vdu_writer;

   localparam int COLS  = 80;
   localparam int ROWS  = 24;
   localparam int CELLS = COLS * ROWS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  cmd = 2'b00;
   logic [4:0]  row = 5'd0;
   logic [6:0]  col = 7'd0;
   logic [7:0]  ch = 8'd0;
   logic [7:0]  at = 8'd0;
   logic        o_ready;
   logic [10:0] o_vram_addr;
   logic [7:0]  o_char_data;
   logic [7:0]  o_attr_data;
   logic        o_vram_we;
   logic [4:0]  o_counter;
   logic        o_counter_valid;
`ifdef VDU_WRITER_ERR_EN
   logic        o_err;
`endif

   vdu_writer dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_valid         (valid),
      .o_ready         (o_ready),
      .i_cmd           (cmd),
      .i_row           (row),
      .i_col           (col),
      .i_char          (ch),
      .i_attr          (at),
      .o_vram_addr     (o_vram_addr),
      .o_char_data     (o_char_data),
      .o_attr_data     (o_attr_data),
      .o_vram_we       (o_vram_we),
      .o_counter       (o_counter),
      .o_counter_valid (o_counter_valid)
`ifdef VDU_WRITER_ERR_EN
      ,
      .o_err           (o_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] c;
      logic [4:0] r;
      logic [6:0] co;
      logic [7:0] h;
      logic [7:0] a;
      int         first;
      int         n;
      logic [7:0] ech;
      logic [7:0] eat;
      int         estr;
      int         ecnt;
      int         ebusy;
      int         eerr;
   } vec_t;

   vec_t tbl[12];

   int n_vec = 0;
   int n_err = 0;
   int wr_addr[$];
   logic [7:0] wr_ch[$];
   logic [7:0] wr_at[$];
   int strobes, strobe_val, strobe_idx, busy;
   int stray = 0;
   int m_scroll = 0;
   int m_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Present one command, then record every cycle until o_ready returns.
   task automatic send(input logic [1:0] c, input logic [4:0] r, input logic [6:0] co,
                       input logic [7:0] h, input logic [7:0] a);
      int w = 0;
      while (!o_ready && w < 4000) begin
         @(posedge clk); #1; w++;
      end
      if (!o_ready) check("ready_wait_timeout", 0, 1);
      cmd = c; row = r; col = co; ch = h; at = a; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      wr_addr.delete(); wr_ch.delete(); wr_at.delete();
      strobes = 0; strobe_val = -1; strobe_idx = -1; busy = 0;
      while (!o_ready && busy < 3000) begin
         if (o_vram_we) begin
            wr_addr.push_back(int'(o_vram_addr));
            wr_ch.push_back(o_char_data);
            wr_at.push_back(o_attr_data);
         end
         if (o_counter_valid) begin
            strobes++;
            strobe_val = int'(o_counter);
            if (strobe_idx < 0) strobe_idx = busy;
         end
         busy++;
         @(posedge clk); #1;
      end
      if (o_vram_we || o_counter_valid) stray++;
   endtask

   task automatic verify(input string tag, input int first, input int n, input logic [7:0] ech,
                         input logic [7:0] eat, input int estr, input int ecnt, input int ebusy);
      int bad = 0;
      check({tag, " nwr"}, wr_addr.size(), n);
      for (int i = 0; i < wr_addr.size(); i++)
         if (i < n && (wr_addr[i] != first + i || wr_ch[i] !== ech || wr_at[i] !== eat)) bad++;
      if (n > 0) check({tag, " wr_seq_bad"}, bad, 0);
      check({tag, " strobes"}, strobes, estr);
      if (estr > 0) begin
         check({tag, " strobe_cnt"}, strobe_val, ecnt);
         check({tag, " strobe_cyc"}, strobe_idx, 0);
      end
      check({tag, " counter"}, int'(o_counter), ecnt);
      check({tag, " busy"}, busy, ebusy);
   endtask

   // Reference model: the effect of one command on the screen, expressed as a
   // contiguous run of blanked or written cells plus the new scroll offset.
   task automatic model(input logic [1:0] c, input int r, input int co,
                        input logic [7:0] h, input logic [7:0] a,
                        output int first, output int n, output logic [7:0] ech,
                        output logic [7:0] eat, output int estr, output int ebusy);
      first = 0; n = 0; ech = 8'h20; eat = 8'h00; estr = 0; ebusy = 1;
      case (c)
         2'b00: begin
            if (r < ROWS && co < COLS) begin
               first = ((r + m_scroll) % ROWS) * COLS + co;
               n = 1; ech = h; eat = a;
            end else m_err = 1;
         end
         2'b01: begin
            m_scroll = 0; n = CELLS; estr = 1; ebusy = CELLS; m_err = 0;
         end
         2'b10: begin
            first = m_scroll * COLS; n = COLS; estr = 1; ebusy = COLS;
            m_scroll = (m_scroll + 1) % ROWS;
         end
         default: begin
            if (r < ROWS) begin
               m_scroll = r; estr = 1;
            end else m_err = 1;
         end
      endcase
   endtask

   initial begin
      int first, n, estr, ebusy, rc, rr, rco;
      logic [7:0] ech, eat;

      tbl[0]  = '{2'b00, 5'd0,  7'd0,  8'h41, 8'h08, 0,    1,     8'h41, 8'h08, 0, 0,  1,     0};
      tbl[1]  = '{2'b11, 5'd5,  7'd0,  8'h00, 8'h00, 0,    0,     8'h20, 8'h00, 1, 5,  1,     0};
      tbl[2]  = '{2'b00, 5'd20, 7'd79, 8'h55, 8'h07, 159,  1,     8'h55, 8'h07, 0, 5,  1,     0};
      tbl[3]  = '{2'b00, 5'd3,  7'd80, 8'h66, 8'h01, 0,    0,     8'h20, 8'h00, 0, 5,  1,     1};
      tbl[4]  = '{2'b11, 5'd24, 7'd0,  8'h00, 8'h00, 0,    0,     8'h20, 8'h00, 0, 5,  1,     1};
      tbl[5]  = '{2'b01, 5'd0,  7'd0,  8'h00, 8'h00, 0,    1920,  8'h20, 8'h00, 1, 0,  1920,  0};
      tbl[6]  = '{2'b00, 5'd24, 7'd0,  8'h12, 8'h34, 0,    0,     8'h20, 8'h00, 0, 0,  1,     1};
      tbl[7]  = '{2'b10, 5'd0,  7'd0,  8'h00, 8'h00, 0,    80,    8'h20, 8'h00, 1, 1,  80,    1};
      tbl[8]  = '{2'b11, 5'd23, 7'd0,  8'h00, 8'h00, 0,    0,     8'h20, 8'h00, 1, 23, 1,     1};
      tbl[9]  = '{2'b10, 5'd0,  7'd0,  8'h00, 8'h00, 1840, 80,    8'h20, 8'h00, 1, 0,  80,    1};
      tbl[10] = '{2'b00, 5'd23, 7'd0,  8'h7e, 8'h1f, 1840, 1,     8'h7e, 8'h1f, 0, 0,  1,     1};
      tbl[11] = '{2'b01, 5'd0,  7'd0,  8'h00, 8'h00, 0,    1920,  8'h20, 8'h00, 1, 0,  1920,  0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst ready", int'(o_ready), 1);
      check("rst we", int'(o_vram_we), 0);
      check("rst addr", int'(o_vram_addr), 0);
      check("rst counter", int'(o_counter), 0);
      check("rst cvalid", int'(o_counter_valid), 0);
`ifdef VDU_WRITER_ERR_EN
      check("rst err", int'(o_err), 0);
`endif

      for (int i = 0; i < 12; i++) begin
         send(tbl[i].c, tbl[i].r, tbl[i].co, tbl[i].h, tbl[i].a);
         verify($sformatf("tbl%0d", i), tbl[i].first, tbl[i].n, tbl[i].ech, tbl[i].eat,
                tbl[i].estr, tbl[i].ecnt, tbl[i].ebusy);
`ifdef VDU_WRITER_ERR_EN
         check($sformatf("tbl%0d err", i), int'(o_err), tbl[i].eerr);
`endif
         $display("vec tbl%0d cmd=%0d row=%0d col=%0d writes=%0d counter=%0d",
                  i, tbl[i].c, tbl[i].r, tbl[i].co, wr_addr.size(), o_counter);
      end
      m_scroll = 0; m_err = 0;

      for (int k = 0; k < ROWS; k++) begin
         send(2'b10, 5'd0, 7'd0, 8'h00, 8'h00);
         verify($sformatf("scroll%0d", k), k * COLS, COLS, 8'h20, 8'h00, 1, (k + 1) % ROWS, COLS);
         $display("vec scroll%0d counter=%0d first_addr=%0d", k, o_counter,
                  wr_addr.size() > 0 ? wr_addr[0] : -1);
      end

      // Reset in the middle of a clear fill.
      send(2'b11, 5'd7, 7'd0, 8'h00, 8'h00);
      check("pre-clear counter", int'(o_counter), 7);
      cmd = 2'b01; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (499) begin @(posedge clk); #1; end
      check("midclear we", int'(o_vram_we), 1);
      check("midclear addr", int'(o_vram_addr), 499);
      rst_n = 1'b0;
      #1;
      check("async rst we", int'(o_vram_we), 0);
      check("async rst ready", int'(o_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post rst ready", int'(o_ready), 1);
      check("post rst we", int'(o_vram_we), 0);
      check("post rst counter", int'(o_counter), 0);
      m_scroll = 0; m_err = 0;
      send(2'b00, 5'd1, 7'd0, 8'h31, 8'h02);
      verify("post rst write", 80, 1, 8'h31, 8'h02, 0, 0, 1);
      $display("vec reset_mid_clear write_addr=%0d", wr_addr.size() > 0 ? wr_addr[0] : -1);

      for (int t = 0; t < 150; t++) begin
         rc = int'($urandom_range(0, 99));
         rr  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
         rco = ($urandom_range(0, 9) == 0) ? int'($urandom_range(80, 127)) : int'($urandom_range(0, 79));
         cmd = (rc < 50) ? 2'b00 : (rc < 54) ? 2'b01 : (rc < 78) ? 2'b10 : 2'b11;
         ch = 8'($urandom); at = 8'($urandom);
         model(cmd, rr, rco, ch, at, first, n, ech, eat, estr, ebusy);
         send(cmd, 5'(rr), 7'(rco), ch, at);
         verify($sformatf("rnd%0d", t), first, n, ech, eat, estr, m_scroll, ebusy);
`ifdef VDU_WRITER_ERR_EN
         check($sformatf("rnd%0d err", t), int'(o_err), m_err);
`endif
         $display("vec rnd%0d cmd=%0d row=%0d col=%0d writes=%0d counter=%0d",
                  t, cmd, rr, rco, wr_addr.size(), o_counter);
      end

      check("stray we/strobe in idle", stray, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vdu_writer.md
Name: vdu_writer

Overview:
- Host-side writer for the VDU-80 character RAM; the write end of the VRAM/scroll interface that the display block reads.
- Accepts character-write, clear-screen, scroll-up and set-scroll commands over a valid/ready handshake.
- Maps logical (row, col) to physical VRAM address using the current scroll offset and drives the VRAM write port.
- Publishes the scroll counter to the display as a counter value plus a one-cycle valid strobe.

Parameters:
- COLS, 80, characters per row.
- ROWS, 24, character rows; scroll counter wraps modulo ROWS.
- BLANK_CHAR, 8'h20, character code written by clear and scroll operations (attribute written as 8'h00).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  command valid.
- o_ready  out  1  high only in IDLE; a command is accepted when i_valid && o_ready.
- i_cmd  in  2  00 write char, 01 clear screen, 10 scroll up, 11 set scroll.
- i_row  in  5  logical row (cmd 00); new scroll value (cmd 11).
- i_col  in  7  logical column (cmd 00).
- i_char  in  8  character code (cmd 00).
- i_attr  in  8  attribute byte (cmd 00).
- o_vram_addr  out  11  physical VRAM address, prow*COLS + col.
- o_char_data  out  8  character write data.
- o_attr_data  out  8  attribute write data.
- o_vram_we  out  1  VRAM write enable, one write per cycle.
- o_counter  out  5  current scroll counter.
- o_counter_valid  out  1  one-cycle strobe whenever o_counter changes or is re-published.

Behaviour:
- Reset values: all outputs 0 except o_ready, which is 1 when reset deasserts. Scroll counter = 0, state = IDLE. Reset is asynchronous, so asserting it mid-operation aborts any clear or scroll fill immediately; no further writes occur.
- Address mapping: prow = (row + scroll) mod ROWS, computed without a divider (add, then subtract ROWS if the sum is >= ROWS). addr = prow*80 + col, maximum 1919.
- States:
  - IDLE: o_ready=1.
  - WRITE: one cycle.
  - FILL: down-counter over a cell range.
  - PUBLISH: one cycle.
- Cmd 00, accepted in cycle N:
  - If row<ROWS and col<COLS: WRITE in cycle N+1 with o_vram_we=1 and registered addr/char/attr.
  - Otherwise: no write; the block still spends one cycle and returns to IDLE.
  - o_ready is high again in N+2.
- Cmd 01:
  - Scroll counter set to 0.
  - o_counter_valid=1 and o_counter=0 in cycle N+1.
  - FILL writes BLANK_CHAR/8'h00 to addresses 0..1919 on cycles N+1..N+1920, ascending.
  - IDLE at N+1921.
- Cmd 10:
  - new = (scroll+1) mod ROWS, so 23 wraps to 0.
  - o_counter=new with o_counter_valid=1 in N+1.
  - FILL clears the newly exposed bottom line, physical row = old scroll: addresses old*80 .. old*80+79 on N+1..N+80.
  - IDLE at N+81.
- Cmd 11:
  - If i_row<ROWS: scroll=i_row, and PUBLISH in N+1 with the strobe.
  - If i_row>=ROWS: ignored, no strobe.
  - Either way o_ready returns in N+2.
- o_vram_we is low in every cycle outside WRITE/FILL. o_counter_valid is never high for more than one cycle per command.
- i_valid while o_ready=0 is not accepted. The host holds the command and its data stable until acceptance.
- Back-to-back commands: a command presented in the first IDLE cycle is accepted in that cycle, with no extra bubble.

Optional Feature:
- Macro: VDU_WRITER_ERR_EN.
- Defined:
  - Adds output o_err (1 bit), reset 0.
  - o_err is set in the cycle after an out-of-range cmd 00 or cmd 11 is accepted.
  - Sticky; cleared only by an accepted cmd 01 (0 from N+1) or by reset.
- Not defined: the port is absent and out-of-range commands are silently ignored.

Test Plan:
- Reset, then cmd 00 row=0 col=0 char=8'h41 attr=8'h08 -> N+1: we=1, addr=0, char=41, attr=08; N+2: ready=1.
- cmd 11 row=5, then cmd 00 row=20 col=79 -> counter_valid pulse with counter=5; write at addr ((20+5)-24)*80+79 = 159.
- cmd 01 -> exactly 1920 we pulses, addr 0..1919, data 20/00; counter=0 with one valid pulse; ready after 1921 cycles.
- Scroll 24 times from 0 -> counters 1..23 then 0. Each scroll gives 80 writes starting at old*80; the 24th scroll clears addr 1840..1919.
- cmd 00 col=80, and cmd 11 row=24 -> no we, no strobe. With VDU_WRITER_ERR_EN, o_err=1 until the next cmd 01.
- Assert i_rst_n low at cycle 500 of a clear -> we=0 and ready=1 after release, counter=0; a following write at row=1 col=0 goes to addr 80.
